dm_responder: RTL and testbench

DM_RESPONDER -- requirements
Module: dm_responder

---
 rtl/dm_pkg.sv | 39 +++
 rtl/dm_lane_align.sv | 59 +++++
 rtl/dm_responder.sv | 185 ++++++++++++++++++
 tb/tb_dm_responder.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dm_pkg.sv
// Shared definitions for the data-memory responder: func3 width codes, FSM states, lane masks.
// Latency: n/a (types and a pure combinational helper only).
// Backpressure: n/a.
package dm_pkg;

  // RV32I load/store width codes carried on req_func3
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dm_state_t;

  // One bit per byte lane of a 32-bit word, bit 0 = bits [7:0]
  typedef logic [3:0] lane_mask_t;

  // Encoding/alignment faults that do not depend on the memory size
  function automatic logic dm_f3_fault(input logic [2:0] func3,
                                       input logic       we,
                                       input logic [1:0] addr_lo);
    logic bad;
    bad = 1'b0;
    case (func3)
      F3_B:         bad = 1'b0;
      F3_BU:        bad = we;
      F3_H:         bad = addr_lo[0];
      F3_HU:        bad = we | addr_lo[0];
      F3_W:         bad = (addr_lo != 2'b00);
      default:      bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/dm_lane_align.sv
// Byte-lane steering: store lane mask + data replication, load extraction + sign/zero extension.
// Latency: purely combinational.
// Backpressure: none; operates on whatever request fields the parent presents.
module dm_lane_align
  import dm_pkg::*;
(
  input  logic [2:0]  func3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output lane_mask_t  lane_mask,
  output logic [31:0] wdata_rep,
  output logic [31:0] rdata_ext
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = rword[{addr_lo, 3'b000} +: 8];
  assign half_sel = rword[{addr_lo[1], 4'b0000} +: 16];

  // Select write lanes and replicate store data so every lane carries the right bytes
  always_comb begin
    lane_mask = '0;
    wdata_rep = wdata;
    case (func3)
      F3_B, F3_BU: begin
        lane_mask = 4'b0001 << addr_lo;
        wdata_rep = {4{wdata[7:0]}};
      end
      F3_H, F3_HU: begin
        lane_mask = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata_rep = {2{wdata[15:0]}};
      end
      F3_W: begin
        lane_mask = 4'b1111;
        wdata_rep = wdata;
      end
      default: begin
        lane_mask = '0;
        wdata_rep = wdata;
      end
    endcase
  end

  // Right-align the addressed bytes of the read word and extend to 32 bits
  always_comb begin
    rdata_ext = '0;
    case (func3)
      F3_B:    rdata_ext = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   rdata_ext = {24'h0, byte_sel};
      F3_H:    rdata_ext = {{16{half_sel[15]}}, half_sel};
      F3_HU:   rdata_ext = {16'h0, half_sel};
      F3_W:    rdata_ext = rword;
      default: rdata_ext = '0;
    endcase
  end

endmodule

// File: rtl/dm_responder.sv
// Single-outstanding load/store responder over a DEPTH_WORDS x 32-bit store; optional counters under DM_RESPONDER_STATS_EN.
// Latency: accept -> rsp_valid in WAIT_CYCLES+1 cycles; store commits on the edge entering RESP.
// Backpressure: req_ready only in IDLE; response held stable until rsp_ready.
module dm_responder
  import dm_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [2:0]  req_func3,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
`ifdef DM_RESPONDER_STATS_EN
  ,
  output logic [15:0] stat_loads,
  output logic [15:0] stat_stores,
  output logic [15:0] stat_errors
`endif
);

  localparam int         IDX_W    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0] CNT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  dm_state_t   state, nxt_state;
  logic [3:0]  cnt, cnt_nxt;
  logic        enter_resp;

  logic        cap_we;
  logic [31:0] cap_addr;
  logic [2:0]  cap_func3;
  logic [31:0] cap_wdata;

  // In IDLE the live request is the operand (needed when WAIT_CYCLES=0 commits on the accept edge)
  logic        cur_we;
  logic [31:0] cur_addr;
  logic [2:0]  cur_func3;
  logic [31:0] cur_wdata;
  logic        cur_err;

  logic [31:0]      mem [DEPTH_WORDS];
  logic [IDX_W-1:0] mem_idx;
  logic [31:0]      rword;
  lane_mask_t       lane_mask;
  logic [31:0]      wdata_rep;
  logic [31:0]      rdata_ext;
  logic             wr_en;

  assign cur_we    = (state == IDLE) ? req_we    : cap_we;
  assign cur_addr  = (state == IDLE) ? req_addr  : cap_addr;
  assign cur_func3 = (state == IDLE) ? req_func3 : cap_func3;
  assign cur_wdata = (state == IDLE) ? req_wdata : cap_wdata;

  assign cur_err = dm_f3_fault(cur_func3, cur_we, cur_addr[1:0])
                 | (cur_addr[31:2] >= 30'(DEPTH_WORDS));

  assign mem_idx = cur_addr[IDX_W+1:2];
  assign rword   = mem[mem_idx];
  // Gated by reset so an accept seen while reset is held can never write
  assign wr_en   = enter_resp & cur_we & ~cur_err & reset;

  dm_lane_align u_align (
    .func3     (cur_func3),
    .addr_lo   (cur_addr[1:0]),
    .wdata     (cur_wdata),
    .rword     (rword),
    .lane_mask (lane_mask),
    .wdata_rep (wdata_rep),
    .rdata_ext (rdata_ext)
  );

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= nxt_state;
  end

  // Next-state, wait counter and handshake outputs
  always_comb begin
    nxt_state  = state;
    cnt_nxt    = cnt;
    enter_resp = 1'b0;
    req_ready  = 1'b0;
    rsp_valid  = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (WAIT_CYCLES > 0) begin
            nxt_state = WAIT;
            cnt_nxt   = CNT_LOAD;
          end else begin
            nxt_state  = RESP;
            enter_resp = 1'b1;
          end
        end
      end
      WAIT: begin
        if (cnt == 4'd0) begin
          nxt_state  = RESP;
          enter_resp = 1'b1;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) nxt_state = IDLE;
      end
      default: nxt_state = IDLE;
    endcase
  end

  // Wait counter register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt <= 4'd0;
    else        cnt <= cnt_nxt;
  end

  // Capture every request field on the accepting edge
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cap_we    <= 1'b0;
      cap_addr  <= '0;
      cap_func3 <= '0;
      cap_wdata <= '0;
    end else if (state == IDLE && req_valid) begin
      cap_we    <= req_we;
      cap_addr  <= req_addr;
      cap_func3 <= req_func3;
      cap_wdata <= req_wdata;
    end
  end

  // Response registers load on the edge entering RESP and then stay frozen
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else if (enter_resp) begin
      rsp_err   <= cur_err;
      rsp_rdata <= (cur_err || cur_we) ? 32'h0 : rdata_ext;
    end
  end

  // Byte-lane write; storage is deliberately left out of reset
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (lane_mask[i]) mem[mem_idx][8*i +: 8] <= wdata_rep[8*i +: 8];
      end
    end
  end

`ifdef DM_RESPONDER_STATS_EN
  logic rsp_hs;
  assign rsp_hs = rsp_valid & rsp_ready;

  // Saturating per-class completion counters, bumped on the response handshake
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stat_loads  <= '0;
      stat_stores <= '0;
      stat_errors <= '0;
    end else if (rsp_hs) begin
      if (rsp_err) begin
        if (stat_errors != 16'hFFFF) stat_errors <= stat_errors + 16'd1;
      end else if (cap_we) begin
        if (stat_stores != 16'hFFFF) stat_stores <= stat_stores + 16'd1;
      end else begin
        if (stat_loads != 16'hFFFF) stat_loads <= stat_loads + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_dm_responder.sv
// Randomised + directed bench for dm_responder against a byte-array reference model.
// Latency: checks WAIT_CYCLES+1 accept-to-response and stability under held rsp_ready.
// Backpressure: stalls rsp_ready and presents ignored requests while the DUT is busy.
module tb_dm_responder;

  localparam int DEPTH = 64;
  localparam int WAITC = 3;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [2:0]  req_func3;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
`ifdef DM_RESPONDER_STATS_EN
  logic [15:0] stat_loads, stat_stores, stat_errors;
`endif

  dm_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WAITC)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_func3 (req_func3),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err)
`ifdef DM_RESPONDER_STATS_EN
    ,
    .stat_loads  (stat_loads),
    .stat_stores (stat_stores),
    .stat_errors (stat_errors)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] ref_mem [DEPTH];
  int ref_loads = 0, ref_stores = 0, ref_errs = 0;

  function automatic void ref_exec(input logic we, input logic [31:0] addr, input logic [2:0] f3,
                                   input logic [31:0] wd, output logic err, output logic [31:0] rd);
    logic [31:0] idx, w, v;
    int off, nbytes;
    idx = addr / 4;
    off = int'(addr % 4);
    err = 1'b0;
    rd  = 32'h0;
    if (f3 == 3 || f3 == 6 || f3 == 7)          err = 1'b1;
    if (we && (f3 == 4 || f3 == 5))             err = 1'b1;
    if ((f3 == 1 || f3 == 5) && (off % 2) != 0) err = 1'b1;
    if (f3 == 2 && off != 0)                    err = 1'b1;
    if (idx >= DEPTH)                           err = 1'b1;
    if (err) return;
    w = ref_mem[idx];
    if (we) begin
      nbytes = (f3 == 0) ? 1 : (f3 == 1) ? 2 : 4;
      for (int k = 0; k < nbytes; k++) w[(off + k) * 8 +: 8] = wd[k * 8 +: 8];
      ref_mem[idx] = w;
    end else begin
      case (f3)
        3'd0: begin v = (w >> (off * 8)) & 32'hFF;   rd = (v >= 128)   ? v + 32'hFFFF_FF00 : v; end
        3'd4: rd = (w >> (off * 8)) & 32'hFF;
        3'd1: begin v = (w >> (off * 8)) & 32'hFFFF; rd = (v >= 32768) ? v + 32'hFFFF_0000 : v; end
        3'd5: rd = (w >> (off * 8)) & 32'hFFFF;
        default: rd = w;
      endcase
    end
  endfunction

  // One full transaction: drive, check latency/backpressure/stability, compare against model
  task automatic do_req(input string tag, input logic we, input logic [31:0] addr, input logic [2:0] f3,
                        input logic [31:0] wd, input int hold,
                        output logic [31:0] got_rd, output logic got_err);
    logic        exp_err;
    logic [31:0] exp_rd, rd0;
    logic        e0;
    int          lat;
    ref_exec(we, addr, f3, wd, exp_err, exp_rd);
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_func3 = f3; req_wdata = wd;
    rsp_ready = 1'b0;
    chk({tag, "/idle_rdy"}, req_ready, 1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_we = 1'($urandom); req_addr = $urandom; req_func3 = 3'($urandom); req_wdata = $urandom;
    lat = 1;
    while (!rsp_valid && lat < 40) begin
      if (lat == 1) begin
        req_valid = 1'b1;   // must be ignored while busy
        chk({tag, "/busy_rdy"}, req_ready, 0);
      end
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "/latency"}, lat, WAITC + 1);
    chk({tag, "/rsp_valid"}, rsp_valid, 1);
    rd0 = rsp_rdata;
    e0  = rsp_err;
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      chk({tag, "/hold_rdata"}, rsp_rdata, rd0);
      chk({tag, "/hold_err"}, rsp_err, e0);
      chk({tag, "/hold_rdy"}, req_ready, 0);
      chk({tag, "/hold_valid"}, rsp_valid, 1);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk({tag, "/post_valid"}, rsp_valid, 0);
    chk({tag, "/rdata"}, rd0, exp_rd);
    chk({tag, "/err"}, e0, exp_err);
    if (exp_err) ref_errs++;
    else if (we) ref_stores++;
    else         ref_loads++;
    got_rd  = rd0;
    got_err = e0;
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached, compared %0d mismatched %0d", n_cmp, n_bad);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd, old20;
    logic        er;
    reset = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_func3 = '0; req_wdata = '0;
    rsp_ready = 1'b0;
    #2;
    chk("rst/rsp_valid", rsp_valid, 0);
    chk("rst/rsp_err", rsp_err, 0);
    chk("rst/rsp_rdata", rsp_rdata, 0);
    chk("rst/req_ready", req_ready, 1);
    repeat (3) @(negedge clk);
    reset = 1'b1;

    // Fill every word so the model and the DUT start from known contents
    for (int i = 0; i < DEPTH; i++) do_req("init", 1'b1, 32'(i * 4), 3'd2, $urandom, 0, rd, er);

    // Directed scenarios
    do_req("sw10",  1'b1, 32'h10, 3'd2, 32'hDEADBEEF, 0, rd, er);
    do_req("lw10",  1'b0, 32'h10, 3'd2, 32'h0, 0, rd, er);
    chk("lw10/value", rd, 32'hDEADBEEF);
    chk("lw10/err", er, 0);
    do_req("sb13",  1'b1, 32'h13, 3'd0, 32'h80, 0, rd, er);
    do_req("lb13",  1'b0, 32'h13, 3'd0, 32'h0, 0, rd, er);
    chk("lb13/value", rd, 32'hFFFFFF80);
    do_req("lbu13", 1'b0, 32'h13, 3'd4, 32'h0, 0, rd, er);
    chk("lbu13/value", rd, 32'h00000080);
    do_req("lw10b", 1'b0, 32'h10, 3'd2, 32'h0, 0, rd, er);
    chk("lw10b/value", rd, 32'h80ADBEEF);
    do_req("lw12",  1'b0, 32'h12, 3'd2, 32'h0, 0, rd, er);
    chk("lw12/err", er, 1);
    chk("lw12/rdata", rd, 0);
    do_req("sh11",  1'b1, 32'h11, 3'd1, 32'h1234, 0, rd, er);
    chk("sh11/err", er, 1);
    do_req("lw10c", 1'b0, 32'h10, 3'd2, 32'h0, 5, rd, er);
    chk("lw10c/unchanged", rd, 32'h80ADBEEF);
    do_req("lhu12", 1'b0, 32'h12, 3'd5, 32'h0, 0, rd, er);
    chk("lhu12/value", rd, 32'h000080AD);
    do_req("oor",   1'b0, 32'(DEPTH * 4), 3'd2, 32'h0, 0, rd, er);
    chk("oor/err", er, 1);

    // Reset during WAIT of SW 0x1 @0x20 aborts the store
    old20 = ref_mem[8];
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20; req_func3 = 3'd2; req_wdata = 32'h1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    chk("abort/rsp_valid", rsp_valid, 0);
    chk("abort/req_ready", req_ready, 1);
    chk("abort/rsp_rdata", rsp_rdata, 0);
    chk("abort/rsp_err", rsp_err, 0);
    ref_loads = 0; ref_stores = 0; ref_errs = 0;
    @(negedge clk);
    reset = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("abort/idle_valid", rsp_valid, 0);
    do_req("lw20", 1'b0, 32'h20, 3'd2, 32'h0, 0, rd, er);
    chk("lw20/old", rd, old20);

    // Randomised traffic
    for (int t = 0; t < 150; t++) begin
      logic [31:0] a;
      a = 32'($urandom_range(0, DEPTH + 3) * 4 + $urandom_range(0, 3));
      if ($urandom_range(0, 15) == 0) a = $urandom;
      do_req("rnd", 1'($urandom_range(0, 1)), a, 3'($urandom_range(0, 7)), $urandom,
             $urandom_range(0, 2), rd, er);
    end

`ifdef DM_RESPONDER_STATS_EN
    chk("stat_loads", 32'(stat_loads), 32'(ref_loads));
    chk("stat_stores", 32'(stat_stores), 32'(ref_stores));
    chk("stat_errors", 32'(stat_errors), 32'(ref_errs));
    reset = 1'b0;
    #1;
    chk("stat_rst", 32'(stat_loads) + 32'(stat_stores) + 32'(stat_errors), 0);
    @(negedge clk);
    reset = 1'b1;
    do_req("st_l1", 1'b0, 32'h0, 3'd2, 32'h0, 0, rd, er);
    do_req("st_l2", 1'b0, 32'h4, 3'd0, 32'h0, 0, rd, er);
    do_req("st_s1", 1'b1, 32'h8, 3'd2, 32'h5, 0, rd, er);
    do_req("st_e1", 1'b0, 32'h2, 3'd2, 32'h0, 0, rd, er);
    chk("stat4_loads", 32'(stat_loads), 2);
    chk("stat4_stores", 32'(stat_stores), 1);
    chk("stat4_errors", 32'(stat_errors), 1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
